// File: rtl/jk_cmd_driver.sv
// Command-buffered stimulus engine for a flipflopjk cell: replays queued hold/reset/set/toggle ops
// onto j/k/enable, tracks the expected flop state and flags any divergence from the real q.
module jk_cmd_driver #(
   parameter int CNT_W      = 4,
   parameter int FIFO_DEPTH = 4,
   parameter bit CHK_EN     = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   output logic             cmd_ready,
   input  logic             q_in,
   output logic             jk_en,
   output logic             j,
   output logic             k,
   output logic             q_model,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = CNT_W + 2;

   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   logic [ENT_W-1:0] fifo_mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             full_s;
   logic             empty_s;
   logic             push_s;
   logic             pop_s;
   logic [ENT_W-1:0] head_s;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] rem_r;
   logic [CNT_W-1:0] rem_nxt_s;
   logic             jk_en_r, j_r, k_r, done_r, busy_r, q_model_r, err_r;
   logic             jk_en_nxt_s, j_nxt_s, k_nxt_s, done_nxt_s;

   // Characteristic equation of the driven JK flop.
   function automatic logic jk_next(input logic jv, input logic kv, input logic qv);
      return (jv & ~qv) | (~kv & qv);
   endfunction

   assign full_s    = (count_r == (PTR_W+1)'(FIFO_DEPTH));
   assign empty_s   = (count_r == '0);
   assign cmd_ready = ~full_s;
   assign push_s    = cmd_valid & ~full_s;
   assign head_s    = fifo_mem_r[rd_ptr_r];

   // Command buffer: pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {cmd_op, cmd_cnt};
            wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sequencer next-state: rem counts the enabled cycles still owed after the current one.
   always_comb begin
      state_nxt_s = state_r;
      rem_nxt_s   = rem_r;
      jk_en_nxt_s = jk_en_r;
      j_nxt_s     = j_r;
      k_nxt_s     = k_r;
      done_nxt_s  = 1'b0;
      pop_s       = 1'b0;
      case (state_r)
         IDLE: begin
            jk_en_nxt_s = 1'b0;
            j_nxt_s     = 1'b0;
            k_nxt_s     = 1'b0;
            if (enable && !empty_s) begin
               pop_s                = 1'b1;
               {j_nxt_s, k_nxt_s}   = head_s[ENT_W-1 -: 2];
               rem_nxt_s            = head_s[CNT_W-1:0];
               jk_en_nxt_s          = 1'b1;
               state_nxt_s          = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (!enable) begin
               jk_en_nxt_s = 1'b0;
            end else if (rem_r != '0) begin
               rem_nxt_s   = rem_r - CNT_W'(1);
               jk_en_nxt_s = 1'b1;
            end else if (!empty_s) begin
               pop_s              = 1'b1;
               {j_nxt_s, k_nxt_s} = head_s[ENT_W-1 -: 2];
               rem_nxt_s          = head_s[CNT_W-1:0];
               jk_en_nxt_s        = 1'b1;
            end else begin
               state_nxt_s = IDLE;
               jk_en_nxt_s = 1'b0;
               j_nxt_s     = 1'b0;
               k_nxt_s     = 1'b0;
               done_nxt_s  = 1'b1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            jk_en_nxt_s = 1'b0;
            j_nxt_s     = 1'b0;
            k_nxt_s     = 1'b0;
         end
      endcase
   end

   // Registered sequencer, shadow flop and sticky mismatch flag; model and flop step on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         rem_r     <= '0;
         jk_en_r   <= 1'b0;
         j_r       <= 1'b0;
         k_r       <= 1'b0;
         done_r    <= 1'b0;
         busy_r    <= 1'b0;
         q_model_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         rem_r     <= rem_nxt_s;
         jk_en_r   <= jk_en_nxt_s;
         j_r       <= j_nxt_s;
         k_r       <= k_nxt_s;
         done_r    <= done_nxt_s;
         busy_r    <= (state_nxt_s == RUN);
         q_model_r <= jk_en_r ? jk_next(j_r, k_r, q_model_r) : q_model_r;
         err_r     <= err_r | (CHK_EN & (q_in ^ q_model_r));
      end
   end

   assign jk_en   = jk_en_r;
   assign j       = j_r;
   assign k       = k_r;
   assign q_model = q_model_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign err     = err_r;
endmodule

// File: tb/tb_jk_cmd_driver.sv
// Bench for jk_cmd_driver: an ideal JK flop closes the q loop, a command-level model predicts every
// output each cycle, and directed scenarios pin the model with hand-computed values.
module tb_jk_cmd_driver;
   logic       clk = 1'b0;
   logic       reset, enable, cmd_valid, cmd_ready, q_in;
   logic [1:0] cmd_op;
   logic [3:0] cmd_cnt;
   logic       jk_en, j, k, q_model, busy, done, err;
   int         tests = 0;
   int         fails = 0;
   int         done_cnt = 0;
   int         ecount;

   always #5 clk = ~clk;

   jk_cmd_driver #(.CNT_W(4), .FIFO_DEPTH(4), .CHK_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
      .cmd_cnt(cmd_cnt), .cmd_ready(cmd_ready), .q_in(q_in), .jk_en(jk_en), .j(j), .k(k),
      .q_model(q_model), .busy(busy), .done(done), .err(err)
   );

   function automatic logic jk_apply(input logic [1:0] op, input logic q);
      case (op)
         2'b00:   return q;
         2'b01:   return 1'b0;
         2'b10:   return 1'b1;
         default: return ~q;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Ideal external flop driven by the DUT; force_inv corrupts the feedback for error injection.
   logic flop_q_r = 1'b0;
   logic force_inv = 1'b0;
   assign q_in = flop_q_r ^ force_inv;
   always @(posedge clk) begin
      if (reset) flop_q_r <= 1'b0;
      else if (jk_en) flop_q_r <= jk_apply({j, k}, flop_q_r);
   end

   // Done pulses are counted on the rising edge, where done is stable.
   always @(posedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   // Command-level model: each op owes (cnt+1) enabled cycles; an enabled edge either starts
   // another owed cycle, moves on to the next queued op, or retires to idle with a done pulse.
   typedef struct packed { logic [1:0] op; int total; } cmd_t;
   cmd_t       queue_m[$];
   bit         active_m = 1'b0;
   logic [1:0] op_m = 2'b00;
   int         total_m = 0;
   int         issued_m = 0;
   logic       m_jk_en = 1'b0, m_j = 1'b0, m_k = 1'b0, m_busy = 1'b0, m_done = 1'b0;
   logic       m_q = 1'b0, m_err = 1'b0;
   bit         chk_on = 1'b0;

   always @(posedge clk) begin : model
      cmd_t       c;
      int         pre_size;
      bit         n_active;
      logic [1:0] n_op;
      int         n_total, n_issued;
      logic       n_jk_en, n_done;
      if (reset) begin
         queue_m.delete();
         active_m <= 1'b0; op_m <= 2'b00; total_m <= 0; issued_m <= 0;
         m_jk_en <= 1'b0; m_j <= 1'b0; m_k <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
         m_q <= 1'b0; m_err <= 1'b0;
         chk_on <= 1'b1;
      end else begin
         pre_size = queue_m.size();
         n_active = active_m; n_op = op_m; n_total = total_m; n_issued = issued_m;
         n_jk_en  = 1'b0; n_done = 1'b0;
         if (enable) begin
            if (active_m && issued_m < total_m) begin
               n_issued = issued_m + 1;
               n_jk_en  = 1'b1;
            end else if (pre_size > 0) begin
               c        = queue_m.pop_front();
               n_active = 1'b1; n_op = c.op; n_total = c.total; n_issued = 1;
               n_jk_en  = 1'b1;
            end else begin
               n_done   = active_m;
               n_active = 1'b0;
               n_op     = 2'b00;
            end
         end
         if (cmd_valid && pre_size < 4) queue_m.push_back('{op: cmd_op, total: int'(cmd_cnt) + 1});
         active_m <= n_active; op_m <= n_op; total_m <= n_total; issued_m <= n_issued;
         m_jk_en  <= n_jk_en; m_j <= n_op[1]; m_k <= n_op[0];
         m_busy   <= n_active; m_done <= n_done;
         m_q      <= m_jk_en ? jk_apply({m_j, m_k}, m_q) : m_q;
         m_err    <= m_err | (q_in !== m_q);
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("cmp_jk_en", jk_en, m_jk_en);
         check("cmp_jk", {j, k}, {m_j, m_k});
         check("cmp_busy", busy, m_busy);
         check("cmp_done", done, m_done);
         check("cmp_q_model", q_model, m_q);
         check("cmp_err", err, m_err);
         check("cmp_ready", cmd_ready, (queue_m.size() < 4) ? 1 : 0);
      end
   end

   logic [1:0] jk_exp3 [6] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
   logic [1:0] op3     [3] = '{2'b10, 2'b01, 2'b00};
   logic [3:0] cnt3    [3] = '{4'd1, 4'd0, 4'd2};
   logic [1:0] op4     [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
   logic [3:0] cnt4    [4] = '{4'd1, 4'd1, 4'd2, 4'd0};
   logic [1:0] op6     [3] = '{2'b11, 2'b10, 2'b01};
   logic [3:0] cnt6    [3] = '{4'd7, 4'd0, 4'd0};
   logic       q_exp2  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      reset = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = 4'd0;
      tick();
      tick();
      check("rst_outputs", {jk_en, j, k, q_model, busy, done, err}, 7'd0);
      reset = 1'b0; enable = 1'b1;

      // Single set with cnt=0: one cycle of latency before j/k appear.
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_cnt = 4'd0;
      tick();
      cmd_valid = 1'b0;
      check("t1_ready_after_rst", cmd_ready, 1'b1);
      check("t1_no_fallthrough", jk_en, 1'b0);
      tick();
      check("t1_jk_after_pop", {jk_en, j, k}, 3'b110);
      tick();
      check("t1_q", {q_model, q_in}, 2'b11);
      check("t1_done", done, 1'b1);
      check("t1_err", err, 1'b0);

      // Toggle x4 from q=0.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cmd_valid = 1'b1; cmd_op = 2'b11; cmd_cnt = 4'd3;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_q_seq", q_model, q_exp2[i]);
      end
      check("t2_done", done, 1'b1);

      // Three back-to-back commands, no bubble, single done.
      tick();
      done_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         if (i < 3) begin
            cmd_valid = 1'b1; cmd_op = op3[i]; cmd_cnt = cnt3[i];
         end else begin
            cmd_valid = 1'b0;
         end
         tick();
         if (i >= 1) begin
            check("t3_jk_seq", {jk_en, j, k}, {1'b1, jk_exp3[i-1]});
         end
      end
      tick();
      tick();
      check("t3_done_pulses", done_cnt, 1);
      check("t3_final_q", q_model, 1'b0);

      // Fill while paused, hold the 5th, then pause mid-op.
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'b1; cmd_op = op4[i]; cmd_cnt = cnt4[i];
         tick();
      end
      check("t4_full_ready", cmd_ready, 1'b0);
      cmd_op = 2'b01; cmd_cnt = 4'd0;
      tick();
      check("t4_held_ready", cmd_ready, 1'b0);
      check("t4_paused_idle", jk_en, 1'b0);
      tick();
      enable = 1'b1; ecount = 0;
      tick();
      ecount += int'(jk_en);
      check("t4_ready_after_pop", cmd_ready, 1'b1);
      tick();
      ecount += int'(jk_en);
      cmd_valid = 1'b0;
      tick();
      ecount += int'(jk_en);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t4_pause_jk_en", jk_en, 1'b0);
         check("t4_pause_busy", busy, 1'b1);
         ecount += int'(jk_en);
      end
      enable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         ecount += int'(jk_en);
         if (busy == 1'b0) break;
      end
      check("t4_idle_reached", busy, 1'b0);
      check("t4_done", done, 1'b1);
      check("t4_enabled_cycles", ecount, 9);

      // Corrupt q_in for one cycle during a set op.
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_cnt = 4'd3;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      check("t5_pre_err", err, 1'b0);
      force_inv = 1'b1;
      tick();
      force_inv = 1'b0;
      check("t5_err_set", err, 1'b1);
      for (int i = 0; i < 4; i++) tick();
      check("t5_err_sticky", err, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_err_cleared", err, 1'b0);

      // Reset mid-op with two queued commands.
      done_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1; cmd_op = op6[i]; cmd_cnt = cnt6[i];
         tick();
      end
      cmd_valid = 1'b0;
      tick();
      tick();
      check("t6_busy_before", {busy, jk_en}, 2'b11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_rst_outputs", {jk_en, j, k, q_model, busy, done, err}, 7'd0);
      check("t6_rst_ready", cmd_ready, 1'b1);
      for (int i = 0; i < 3; i++) tick();
      check("t6_no_done", done_cnt, 0);
      check("t6_stays_idle", {busy, jk_en}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
